// File: rtl/cim_row_dma.sv
// cim_row_dma
// -----------
// Bidirectional row DMA between a word-wide memory bus and a CIM macro.
//   LOAD  (mode = 0): fetch num_rows rows of ROW_WORDS bus words starting at
//                     base_addr and write each row into the CIM, beginning at
//                     cim_start_row.
//   STORE (mode = 1): read num_rows CIM rows beginning at cim_start_row and
//                     write them word by word to memory starting at base_addr.
// Word k of a row (k = 0 travels first on the bus) sits in the MSB-most free
// slice of the CIM row: bits [W*(ROW_WORDS-k)-1 : W*(ROW_WORDS-1-k)].
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-low reset
//   start, mode        launch / direction, sampled only while idle
//   abort              drop the current transfer, back to idle, no done
//   base_addr          first memory byte address
//   cim_start_row      first CIM row (row address wraps)
//   num_rows           rows to move, 0 .. 2^ROW_ADDR_WIDTH
//   busy, done         not-idle flag, one-cycle completion pulse
//   mem_*              memory bus request side (req/ack handshake)
//   cim_addr           current CIM row
//   cim_data_in/web    CIM row write (web active-low), cim_wr_done completes
//   cim_rd_req         CIM row read, completed by cim_rd_valid/cim_data_out
//
// Handshakes: a request (mem_req, cim_rd_req, cim_web low) is held, together
// with its address and data, until the responder's completion signal
// (mem_ack, cim_rd_valid, cim_wr_done) is high at a rising edge; the transfer
// happens on exactly that edge. For bus reads mem_rdata is taken in the same
// cycle as mem_ack.
//
// Debug: the FSM state is the internal signal `state`, encoded by the S_*
// localparams below.

module cim_row_dma #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int ROW_WORDS      = 8,
    parameter int ROW_ADDR_WIDTH = 7
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                mode,
    input  logic                                abort,
    input  logic [BUS_ADDR_WIDTH-1:0]           base_addr,
    input  logic [ROW_ADDR_WIDTH-1:0]           cim_start_row,
    input  logic [ROW_ADDR_WIDTH:0]             num_rows,
    output logic                                busy,
    output logic                                done,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [BUS_ADDR_WIDTH-1:0]           mem_addr,
    output logic [BUS_DATA_WIDTH-1:0]           mem_wdata,
    input  logic                                mem_ack,
    input  logic [BUS_DATA_WIDTH-1:0]           mem_rdata,
    output logic [ROW_ADDR_WIDTH-1:0]           cim_addr,
    output logic [ROW_WORDS*BUS_DATA_WIDTH-1:0] cim_data_in,
    output logic                                cim_web,
    input  logic                                cim_wr_done,
    output logic                                cim_rd_req,
    input  logic                                cim_rd_valid,
    input  logic [ROW_WORDS*BUS_DATA_WIDTH-1:0] cim_data_out
);

    localparam int W    = BUS_DATA_WIDTH;
    localparam int WC_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

    localparam logic [WC_W-1:0]           LAST_WORD = WC_W'(ROW_WORDS - 1);
    localparam logic [WC_W-1:0]           ONE_WORD  = WC_W'(1);
    localparam logic [ROW_ADDR_WIDTH:0]   ONE_ROW   = (ROW_ADDR_WIDTH + 1)'(1);
    localparam logic [ROW_ADDR_WIDTH-1:0] ONE_CROW  = ROW_ADDR_WIDTH'(1);
    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_STEP = BUS_ADDR_WIDTH'(BUS_DATA_WIDTH / 8);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_MEM = 3'd1;
    localparam logic [2:0] S_WR_CIM = 3'd2;
    localparam logic [2:0] S_RD_CIM = 3'd3;
    localparam logic [2:0] S_WR_MEM = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]                state;
    logic [ROW_ADDR_WIDTH:0]   rows_q;
    logic [ROW_ADDR_WIDTH:0]   row_cnt;
    logic [WC_W-1:0]           word_cnt;
    logic [BUS_ADDR_WIDTH-1:0] addr_q;
    logic [ROW_ADDR_WIDTH-1:0] cim_addr_q;
    logic [W-1:0]              row_buf [ROW_WORDS];
    logic                      last_row;

    // True while moving the final row; the row counter is bumped on the same
    // edge that leaves the row, so compare against its pre-increment value.
    assign last_row = ((row_cnt + ONE_ROW) == rows_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            rows_q     <= '0;
            row_cnt    <= '0;
            word_cnt   <= '0;
            addr_q     <= '0;
            cim_addr_q <= '0;
            for (int k = 0; k < ROW_WORDS; k++) begin
                row_buf[k] <= '0;
            end
        end else if (abort && (state != S_IDLE)) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rows_q     <= num_rows;
                        row_cnt    <= '0;
                        word_cnt   <= '0;
                        addr_q     <= base_addr;
                        cim_addr_q <= cim_start_row;
                        if (num_rows == '0) begin
                            state <= S_DONE;
                        end else if (mode) begin
                            state <= S_RD_CIM;
                        end else begin
                            state <= S_RD_MEM;
                        end
                    end
                end
                S_RD_MEM: begin
                    if (mem_ack) begin
                        row_buf[word_cnt] <= mem_rdata;
                        addr_q            <= addr_q + ADDR_STEP;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= S_WR_CIM;
                        end else begin
                            word_cnt <= word_cnt + ONE_WORD;
                        end
                    end
                end
                S_WR_CIM: begin
                    if (cim_wr_done) begin
                        cim_addr_q <= cim_addr_q + ONE_CROW;
                        row_cnt    <= row_cnt + ONE_ROW;
                        word_cnt   <= '0;
                        state      <= last_row ? S_DONE : S_RD_MEM;
                    end
                end
                S_RD_CIM: begin
                    if (cim_rd_valid) begin
                        // Unpack so that row_buf[k] is always bus word k.
                        for (int k = 0; k < ROW_WORDS; k++) begin
                            row_buf[k] <= cim_data_out[W*(ROW_WORDS-1-k) +: W];
                        end
                        state <= S_WR_MEM;
                    end
                end
                S_WR_MEM: begin
                    if (mem_ack) begin
                        addr_q <= addr_q + ADDR_STEP;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt   <= '0;
                            cim_addr_q <= cim_addr_q + ONE_CROW;
                            row_cnt    <= row_cnt + ONE_ROW;
                            state      <= last_row ? S_DONE : S_RD_CIM;
                        end else begin
                            word_cnt <= word_cnt + ONE_WORD;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pack the buffer back into the CIM row layout: word 0 in the MSB slice.
    for (genvar g = 0; g < ROW_WORDS; g++) begin : g_pack
        assign cim_data_in[W*(ROW_WORDS-1-g) +: W] = row_buf[g];
    end

    // All strobes decode straight from the state register, so an abort or a
    // reset drops them on the very edge that moves the FSM to idle.
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign mem_req    = (state == S_RD_MEM) || (state == S_WR_MEM);
    assign mem_we     = (state == S_WR_MEM);
    assign mem_addr   = addr_q;
    assign mem_wdata  = row_buf[word_cnt];
    assign cim_addr   = cim_addr_q;
    assign cim_web    = (state != S_WR_CIM);
    assign cim_rd_req = (state == S_RD_CIM);

endmodule

// File: tb/tb_cim_row_dma.sv
// tb_cim_row_dma
// --------------
// Self-checking bench for cim_row_dma (default parameters: 32-bit bus,
// 8 words per row, 7-bit CIM row address).
//   - clock/reset block, cycle counter
//   - memory and CIM responders (ack/valid patterns selectable per test)
//   - monitor that logs every completed handshake into observed queues and
//     checks request stability while a handshake is pending
//   - reference model that lists, from the transfer parameters alone, the
//     bus addresses/data and CIM rows/addresses a transfer must produce
//   - directed test sequence in one initial block, then a one-line report

module tb_cim_row_dma;

    localparam int W     = 32;
    localparam int AW    = 32;
    localparam int RW    = 8;
    localparam int RAW   = 7;
    localparam int NRW   = RAW + 1;
    localparam int RB    = RW * W;
    localparam int NROWS = 1 << RAW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic           abort = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [RAW-1:0] cim_start_row = '0;
    logic [RAW:0]   num_rows = '0;
    logic           busy;
    logic           done;
    logic           mem_req;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [W-1:0]   mem_wdata;
    logic           mem_ack = 1'b0;
    logic [W-1:0]   mem_rdata;
    logic [RAW-1:0] cim_addr;
    logic [RB-1:0]  cim_data_in;
    logic           cim_web;
    logic           cim_wr_done = 1'b0;
    logic           cim_rd_req;
    logic           cim_rd_valid = 1'b0;
    logic [RB-1:0]  cim_data_out;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Responder controls: ack_mode 0 = always, 1 = every 3rd cycle, 2 = random.
    int           ack_mode = 0;
    int           ack_div  = 0;
    bit           cim_rand = 1'b0;
    bit           rd_mode  = 1'b0;
    logic [W-1:0] rd_seed  = 32'h5A17_C3E1;

    logic [RB-1:0] cim_mem [NROWS];

    // Scoreboard queues.
    logic [AW-1:0]  exp_addr_q[$];
    logic [AW-1:0]  obs_addr_q[$];
    logic [W-1:0]   exp_wdata_q[$];
    logic [W-1:0]   obs_wdata_q[$];
    logic [RAW-1:0] exp_cim_q[$];
    logic [RAW-1:0] obs_cim_q[$];
    logic [RB-1:0]  exp_row_q[$];
    logic [RB-1:0]  obs_row_q[$];

    int done_cnt = 0;
    int done_cyc = 0;
    int act_cnt  = 0;

    cim_row_dma #(
        .BUS_DATA_WIDTH (W),
        .BUS_ADDR_WIDTH (AW),
        .ROW_WORDS      (RW),
        .ROW_ADDR_WIDTH (RAW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .abort         (abort),
        .base_addr     (base_addr),
        .cim_start_row (cim_start_row),
        .num_rows      (num_rows),
        .busy          (busy),
        .done          (done),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .cim_addr      (cim_addr),
        .cim_data_in   (cim_data_in),
        .cim_web       (cim_web),
        .cim_wr_done   (cim_wr_done),
        .cim_rd_req    (cim_rd_req),
        .cim_rd_valid  (cim_rd_valid),
        .cim_data_out  (cim_data_out)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference memory / CIM contents ----------------
    function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
        return rd_mode ? ((a * 32'h9E37_79B1) ^ rd_seed) : a;
    endfunction

    always_comb mem_rdata = rd_mode ? ((mem_addr * 32'h9E37_79B1) ^ rd_seed) : mem_addr;
    assign cim_data_out = cim_mem[cim_addr];

    // ---------------- responders ----------------
    always @(negedge clk) begin
        case (ack_mode)
            0: mem_ack = 1'b1;
            1: begin
                ack_div = (ack_div == 2) ? 0 : ack_div + 1;
                mem_ack = (ack_div == 2);
            end
            default: mem_ack = ($urandom_range(0, 2) == 0);
        endcase
        cim_wr_done  = cim_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        cim_rd_valid = cim_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
    end

    // ---------------- check helper ----------------
    task automatic chk(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    // Samples 2 time units after the falling edge: inputs for the coming
    // rising edge are settled, so a handshake seen here completes on it.
    logic           hold_bus = 1'b0;
    logic [AW-1:0]  h_addr;
    logic           h_we;
    logic [W-1:0]   h_wdata;
    logic           hold_cim = 1'b0;
    logic [RB-1:0]  h_row;
    logic [RAW-1:0] h_caddr;

    always begin
        @(negedge clk);
        #2;
        if (rst && !abort) begin
            if (hold_bus) begin
                chk("stable_mem_req", mem_req, 1'b1);
                chk("stable_mem_addr", mem_addr, h_addr);
                chk("stable_mem_we", mem_we, h_we);
                if (h_we) chk("stable_mem_wdata", mem_wdata, h_wdata);
            end
            if (hold_cim) begin
                chk("stable_cim_web", cim_web, 1'b0);
                chk("stable_cim_data_in", cim_data_in, h_row);
                chk("stable_cim_addr", cim_addr, h_caddr);
            end
            if (mem_req && mem_ack) begin
                obs_addr_q.push_back(mem_addr);
                if (mem_we) obs_wdata_q.push_back(mem_wdata);
            end
            if (!cim_web && cim_wr_done) begin
                obs_cim_q.push_back(cim_addr);
                obs_row_q.push_back(cim_data_in);
            end
            if (cim_rd_req && cim_rd_valid) obs_cim_q.push_back(cim_addr);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_req || cim_rd_req || !cim_web) act_cnt++;
            hold_bus = mem_req && !mem_ack;
            h_addr   = mem_addr;
            h_we     = mem_we;
            h_wdata  = mem_wdata;
            hold_cim = !cim_web && !cim_wr_done;
            h_row    = cim_data_in;
            h_caddr  = cim_addr;
        end else begin
            hold_bus = 1'b0;
            hold_cim = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    task automatic build_expected(input logic m, input logic [AW-1:0] base,
                                  input logic [RAW-1:0] srow, input logic [RAW:0] n);
        logic [RB-1:0]  row;
        logic [AW-1:0]  a;
        logic [RAW-1:0] ra;
        exp_addr_q.delete();
        exp_wdata_q.delete();
        exp_cim_q.delete();
        exp_row_q.delete();
        for (int r = 0; r < int'(n); r++) begin
            ra = RAW'((int'(srow) + r) % NROWS);
            if (!m) begin
                row = '0;
                for (int k = 0; k < RW; k++) begin
                    a = base + AW'((r * RW + k) * (W / 8));
                    exp_addr_q.push_back(a);
                    row = (row << W) | RB'(mem_word(a));
                end
                exp_cim_q.push_back(ra);
                exp_row_q.push_back(row);
            end else begin
                exp_cim_q.push_back(ra);
                row = cim_mem[ra];
                for (int k = 0; k < RW; k++) begin
                    a = base + AW'((r * RW + k) * (W / 8));
                    exp_addr_q.push_back(a);
                    exp_wdata_q.push_back(row[RB-1 -: W]);
                    row = row << W;
                end
            end
        end
    endtask

    task automatic clear_obs();
        obs_addr_q.delete();
        obs_wdata_q.delete();
        obs_cim_q.delete();
        obs_row_q.delete();
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ":n_bus"}, obs_addr_q.size(), exp_addr_q.size());
        for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++)
            chk($sformatf("%s:bus_addr[%0d]", tag, i), obs_addr_q[i], exp_addr_q[i]);
        chk({tag, ":n_wdata"}, obs_wdata_q.size(), exp_wdata_q.size());
        for (int i = 0; i < exp_wdata_q.size() && i < obs_wdata_q.size(); i++)
            chk($sformatf("%s:wdata[%0d]", tag, i), obs_wdata_q[i], exp_wdata_q[i]);
        chk({tag, ":n_cim"}, obs_cim_q.size(), exp_cim_q.size());
        for (int i = 0; i < exp_cim_q.size() && i < obs_cim_q.size(); i++)
            chk($sformatf("%s:cim_addr[%0d]", tag, i), obs_cim_q[i], exp_cim_q[i]);
        chk({tag, ":n_rows"}, obs_row_q.size(), exp_row_q.size());
        for (int i = 0; i < exp_row_q.size() && i < obs_row_q.size(); i++)
            chk($sformatf("%s:row[%0d]", tag, i), obs_row_q[i], exp_row_q[i]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ":busy"}, busy, 1'b0);
        chk({tag, ":done"}, done, 1'b0);
        chk({tag, ":mem_req"}, mem_req, 1'b0);
        chk({tag, ":mem_we"}, mem_we, 1'b0);
        chk({tag, ":mem_addr"}, mem_addr, '0);
        chk({tag, ":mem_wdata"}, mem_wdata, '0);
        chk({tag, ":cim_addr"}, cim_addr, '0);
        chk({tag, ":cim_data_in"}, cim_data_in, '0);
        chk({tag, ":cim_web"}, cim_web, 1'b1);
        chk({tag, ":cim_rd_req"}, cim_rd_req, 1'b0);
    endtask

    // ---------------- driver ----------------
    task automatic run_xfer(input string tag, input logic m, input logic [AW-1:0] base,
                            input logic [RAW-1:0] srow, input logic [RAW:0] n, input bit chk_lat);
        int c0;
        int d0;
        int a0;
        bit got;
        build_expected(m, base, srow, n);
        clear_obs();
        d0 = done_cnt;
        a0 = act_cnt;
        @(negedge clk);
        start = 1'b1;
        mode = m;
        base_addr = base;
        cim_start_row = srow;
        num_rows = n;
        c0 = cyc + 1;
        @(negedge clk);
        // Scramble the launch inputs: the DUT must have latched them.
        start = 1'b0;
        mode = ~m;
        base_addr = $urandom;
        cim_start_row = RAW'($urandom);
        num_rows = NRW'($urandom);
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ":done_seen"}, got, 1'b1);
        #3;
        if (chk_lat) chk({tag, ":latency"}, done_cyc - c0, int'(n) * (RW + 1));
        @(negedge clk);
        #3;
        chk({tag, ":done_pulses"}, done_cnt - d0, 1);
        chk({tag, ":busy_after"}, busy, 1'b0);
        if (n == '0) chk({tag, ":no_activity"}, act_cnt - a0, 0);
        compare_all(tag);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [RB-1:0]  row;
        logic           m;
        logic [AW-1:0]  base;
        logic [RAW-1:0] srow;
        logic [RAW:0]   n;
        int             d0;
        bit             got;

        for (int r = 0; r < NROWS; r++) begin
            row = '0;
            for (int k = 0; k < RW; k++) row = (row << W) | RB'($urandom);
            cim_mem[r] = row;
        end

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;

        // LOAD, everything tied high, data = address: done in cycle 19.
        ack_mode = 0; cim_rand = 1'b0; rd_mode = 1'b0;
        run_xfer("load2", 1'b0, 32'h0000_1000, 7'd0, 8'd2, 1'b1);

        // LOAD with an ack every third cycle.
        ack_mode = 1; rd_mode = 1'b1;
        run_xfer("load_ack3", 1'b0, 32'h0000_0040, 7'd5, 8'd1, 1'b0);

        // STORE across the CIM row wrap: 126, 127, 0.
        ack_mode = 0;
        run_xfer("store_wrap", 1'b1, 32'h0000_3000, 7'd126, 8'd3, 1'b0);

        // STORE with an ack every third cycle.
        ack_mode = 1;
        run_xfer("store_ack3", 1'b1, 32'h0000_5004, 7'd40, 8'd2, 1'b0);

        // Zero rows, both directions.
        ack_mode = 0;
        run_xfer("zero_load", 1'b0, 32'h0000_7000, 7'd3, 8'd0, 1'b1);
        run_xfer("zero_store", 1'b1, 32'h0000_7000, 7'd3, 8'd0, 1'b1);

        // Bus address wrap at the top of the address space.
        ack_mode = 2; cim_rand = 1'b1;
        run_xfer("addr_wrap", 1'b0, 32'hFFFF_FFF4, 7'd127, 8'd2, 1'b0);

        // Randomised transfers.
        for (int t = 0; t < 6; t++) begin
            m    = 1'($urandom_range(0, 1));
            base = $urandom;
            srow = RAW'($urandom);
            n    = NRW'($urandom_range(1, 5));
            run_xfer($sformatf("rand%0d", t), m, base, srow, n, 1'b0);
        end

        // Abort during the CIM write of row 1 of 4.
        ack_mode = 0; cim_rand = 1'b0;
        build_expected(1'b0, 32'h0000_4000, 7'd20, 8'd4);
        clear_obs();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base_addr = 32'h0000_4000; cim_start_row = 7'd20; num_rows = 8'd4;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!cim_web && (obs_row_q.size() == 1)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort:reach_row1_write", got, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort:busy", busy, 1'b0);
        chk("abort:cim_web", cim_web, 1'b1);
        chk("abort:mem_req", mem_req, 1'b0);
        chk("abort:mem_we", mem_we, 1'b0);
        chk("abort:cim_rd_req", cim_rd_req, 1'b0);
        chk("abort:done", done, 1'b0);
        repeat (3) @(negedge clk);
        #3;
        chk("abort:no_done", done_cnt - d0, 0);
        chk("abort:busy_stays_low", busy, 1'b0);
        chk("abort:n_bus", obs_addr_q.size(), 16);
        chk("abort:n_rows", obs_row_q.size(), 1);
        if (obs_row_q.size() >= 1) chk("abort:row0", obs_row_q[0], exp_row_q[0]);
        run_xfer("after_abort", 1'b0, 32'h0000_6000, 7'd9, 8'd1, 1'b1);

        // Reset in the middle of a STORE, with a start pulse while busy.
        build_expected(1'b1, 32'h0000_2000, 7'd10, 8'd3);
        clear_obs();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; base_addr = 32'h0000_2000; cim_start_row = 7'd10; num_rows = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid:busy_before_pulse", busy, 1'b1);
        start = 1'b1; mode = 1'b0; base_addr = 32'h0000_9000; cim_start_row = 7'd0; num_rows = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_mid:busy_after_pulse", busy, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        rst = 1'b1;
        @(negedge clk);
        #3;
        chk("rst_mid:idle_after", busy, 1'b0);
        chk("rst_mid:no_done", done_cnt - d0, 0);
        chk("rst_mid:n_writes", obs_wdata_q.size(), 9);
        for (int i = 0; i < obs_wdata_q.size() && i < exp_wdata_q.size(); i++) begin
            chk($sformatf("rst_mid:wdata[%0d]", i), obs_wdata_q[i], exp_wdata_q[i]);
            chk($sformatf("rst_mid:waddr[%0d]", i), obs_addr_q[i], exp_addr_q[i]);
        end

        // Full row count: 128 rows, CIM address wraps back to the start row.
        rd_mode = 1'b1;
        run_xfer("load_full", 1'b0, 32'h0001_0000, 7'd77, 8'h80, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
